// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial controller sharing one 8-bit RAM port between
// instruction fetch and the load/store buffer.
//
// One word/half/byte request is accepted at a time, in priority order
// store > load > fetch. The controller then sequences the byte accesses and
// returns a one-cycle done pulse to the requester that won. Load data is
// zero- or sign-extended before it is returned.
//
// roll_back aborts loads and fetches. A store that has already been accepted
// is committed, so it always runs to completion.
//
// Build option:
//   IO_STALL_EN - when defined, a store to an IO address (store_address[17:16]
//                 == 2'b11) is held in IDLE while io_buffer_full is high.
//                 Nothing of lower priority is accepted in its place. When
//                 undefined, io_buffer_full is ignored.
//
// Ports:
//   clk_in, rst_in            clock; synchronous active-high reset
//   rdy_in                    global ready; low freezes every register
//   roll_back                 mispredict flush
//   io_buffer_full            UART write buffer full
//   mem_din/mem_dout/mem_a/mem_wr   RAM byte port (read data valid the cycle
//                                   after its address)
//   fetch_req/fetch_addr      fetch request -> fetch_done/fetch_data
//   lsb_load/load_*           load request  -> finish_load/data_load
//   lsb_store/store_*         store request -> finish_store
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_data,
  input  logic        lsb_load,
  input  logic [31:0] load_address,
  input  logic [1:0]  load_size,
  input  logic        load_unsigned,
  output logic        finish_load,
  output logic [31:0] data_load,
  input  logic        lsb_store,
  input  logic [31:0] store_address,
  input  logic [1:0]  store_size,
  input  logic [31:0] data_store,
  output logic        finish_store
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0] addr_q, addr_d;
  logic [2:0]  len_q, len_d;     // byte count: 1, 2 or 4
  logic [2:0]  cnt_q, cnt_d;
  logic        src_fetch_q, src_fetch_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] wdata_q, wdata_d;
  logic [23:0] rbuf_q, rbuf_d;   // bytes 0..2; the final byte comes straight from mem_din

  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        fetch_done_q, fetch_done_d;
  logic        finish_load_q, finish_load_d;
  logic        finish_store_q, finish_store_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic [31:0] data_load_q, data_load_d;

  function automatic logic [2:0] len_of(input logic [1:0] size);
    case (size)
      2'b00:   len_of = 3'd1;
      2'b01:   len_of = 3'd2;
      default: len_of = 3'd4;
    endcase
  endfunction

  // Request acceptance in IDLE
  logic io_stall;
`ifdef IO_STALL_EN
  assign io_stall = lsb_store && io_buffer_full && (store_address[17:16] == 2'b11);
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  logic take_store, take_load, take_fetch;
  // A stalled store still blocks loads and fetches, which keeps memory order.
  assign take_store = lsb_store && !io_stall;
  assign take_load  = !lsb_store && lsb_load && !roll_back;
  assign take_fetch = !lsb_store && !lsb_load && fetch_req && !roll_back;

  logic last_read, last_write;
  assign last_read  = (cnt_q == (len_q - 3'd1));
  assign last_write = (cnt_q == len_q);

  // Assemble the read word. The byte arriving on this edge is the top byte.
  logic [31:0] assembled, extended;
  always_comb begin
    case (len_q)
      3'd1:    assembled = {24'd0, mem_din};
      3'd2:    assembled = {16'd0, mem_din, rbuf_q[7:0]};
      default: assembled = {mem_din, rbuf_q[23:0]};
    endcase
    case (len_q)
      3'd1:    extended = unsigned_q ? {24'd0, assembled[7:0]}
                                     : {{24{assembled[7]}}, assembled[7:0]};
      3'd2:    extended = unsigned_q ? {16'd0, assembled[15:0]}
                                     : {{16{assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  logic [7:0] wbyte;
  always_comb begin
    case (cnt_q[1:0])
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      2'd3:    wbyte = wdata_q[31:24];
      default: wbyte = wdata_q[7:0];
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (take_store) begin
          state_d = StWrite;
        end else if (take_load || take_fetch) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (roll_back) begin
          state_d = StIdle;
        end else if (last_read) begin
          state_d = StDone;
        end
      end
      StWrite: begin
        if (last_write) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    addr_d         = addr_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    src_fetch_d    = src_fetch_q;
    unsigned_d     = unsigned_q;
    wdata_d        = wdata_q;
    rbuf_d         = rbuf_q;
    mem_a_d        = mem_a_q;
    mem_dout_d     = mem_dout_q;
    mem_wr_d       = mem_wr_q;
    fetch_data_d   = fetch_data_q;
    data_load_d    = data_load_q;
    fetch_done_d   = 1'b0;
    finish_load_d  = 1'b0;
    finish_store_d = 1'b0;
    case (state_q)
      StIdle: begin
        mem_a_d    = 32'd0;
        mem_dout_d = 8'd0;
        mem_wr_d   = 1'b0;
        if (roll_back) begin
          fetch_data_d = 32'd0;
          data_load_d  = 32'd0;
        end
        if (take_store) begin
          addr_d     = store_address;
          len_d      = len_of(store_size);
          wdata_d    = data_store;
          cnt_d      = 3'd1;           // byte 0 goes out on this edge
          mem_a_d    = store_address;
          mem_dout_d = data_store[7:0];
          mem_wr_d   = 1'b1;
        end else if (take_load) begin
          addr_d      = load_address;
          len_d       = len_of(load_size);
          src_fetch_d = 1'b0;
          unsigned_d  = load_unsigned;
          cnt_d       = 3'd0;
          mem_a_d     = load_address;
        end else if (take_fetch) begin
          addr_d      = fetch_addr;
          len_d       = 3'd4;
          src_fetch_d = 1'b1;
          unsigned_d  = 1'b0;
          cnt_d       = 3'd0;
          mem_a_d     = fetch_addr;
        end
      end
      StRead: begin
        if (roll_back) begin
          mem_a_d      = 32'd0;
          cnt_d        = 3'd0;
          fetch_data_d = 32'd0;
          data_load_d  = 32'd0;
        end else begin
          case (cnt_q[1:0])
            2'd0:    rbuf_d[7:0]   = mem_din;
            2'd1:    rbuf_d[15:8]  = mem_din;
            2'd2:    rbuf_d[23:16] = mem_din;
            default: ;
          endcase
          cnt_d = cnt_q + 3'd1;
          if (last_read) begin
            mem_a_d = 32'd0;
            if (src_fetch_q) begin
              fetch_done_d = 1'b1;
              fetch_data_d = assembled;
            end else begin
              finish_load_d = 1'b1;
              data_load_d   = extended;
            end
          end else begin
            mem_a_d = addr_q + {29'd0, cnt_q} + 32'd1;
          end
        end
      end
      StWrite: begin
        // roll_back is deliberately ignored: the store is already committed.
        if (last_write) begin
          mem_a_d        = 32'd0;
          mem_dout_d     = 8'd0;
          mem_wr_d       = 1'b0;
          finish_store_d = 1'b1;
        end else begin
          mem_a_d    = addr_q + {29'd0, cnt_q};
          mem_dout_d = wbyte;
          cnt_d      = cnt_q + 3'd1;
        end
      end
      default: begin
        if (roll_back) begin
          fetch_data_d = 32'd0;
          data_load_d  = 32'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q         <= 32'd0;
      len_q          <= 3'd1;
      cnt_q          <= 3'd0;
      src_fetch_q    <= 1'b0;
      unsigned_q     <= 1'b0;
      wdata_q        <= 32'd0;
      rbuf_q         <= 24'd0;
      mem_a_q        <= 32'd0;
      mem_dout_q     <= 8'd0;
      mem_wr_q       <= 1'b0;
      fetch_done_q   <= 1'b0;
      finish_load_q  <= 1'b0;
      finish_store_q <= 1'b0;
      fetch_data_q   <= 32'd0;
      data_load_q    <= 32'd0;
    end else if (rdy_in) begin
      addr_q         <= addr_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      src_fetch_q    <= src_fetch_d;
      unsigned_q     <= unsigned_d;
      wdata_q        <= wdata_d;
      rbuf_q         <= rbuf_d;
      mem_a_q        <= mem_a_d;
      mem_dout_q     <= mem_dout_d;
      mem_wr_q       <= mem_wr_d;
      fetch_done_q   <= fetch_done_d;
      finish_load_q  <= finish_load_d;
      finish_store_q <= finish_store_d;
      fetch_data_q   <= fetch_data_d;
      data_load_q    <= data_load_d;
    end
  end

  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q;
  assign fetch_done   = fetch_done_q;
  assign finish_load  = finish_load_q;
  assign finish_store = finish_store_q;
  assign fetch_data   = fetch_data_q;
  assign data_load    = data_load_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed requests, a transaction-level model of
// the expected bus activity, and hand-computed literal checks.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_data;
  logic        lsb_load;
  logic [31:0] load_address;
  logic [1:0]  load_size;
  logic        load_unsigned;
  logic        finish_load;
  logic [31:0] data_load;
  logic        lsb_store;
  logic [31:0] store_address;
  logic [1:0]  store_size;
  logic [31:0] data_store;
  logic        finish_store;

  mem_arbiter dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .roll_back     (roll_back),
    .io_buffer_full(io_buffer_full),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_done    (fetch_done),
    .fetch_data    (fetch_data),
    .lsb_load      (lsb_load),
    .load_address  (load_address),
    .load_size     (load_size),
    .load_unsigned (load_unsigned),
    .finish_load   (finish_load),
    .data_load     (data_load),
    .lsb_store     (lsb_store),
    .store_address (store_address),
    .store_size    (store_size),
    .data_store    (data_store),
    .finish_store  (finish_store)
  );

  always #5 clk_in = ~clk_in;

  // RAM driven by the DUT, and the model's own copy of memory
  logic [7:0] ram  [0:65535];
  logic [7:0] mram [0:65535];
  assign mem_din = ram[mem_a[15:0]];

  int n_cmp = 0;
  int n_fail = 0;

  // Model: phase 0 idle, 1 transfer in progress, 2 done cycle.
  // m_j counts edges since the acceptance edge.
  int          m_phase, m_kind, m_n, m_j;  // kind: 0 fetch, 1 load, 2 store
  logic [31:0] m_addr, m_wdata, m_result;
  logic        m_uns;
  logic [31:0] e_a, e_fdata, e_ldata;
  logic [7:0]  e_dout;
  logic        e_wr, e_fd, e_fl, e_fs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int n_of(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic drive_offset(input int j);
    e_a = m_addr + 32'(j);
    if (m_kind == 2) begin
      e_wr   = 1'b1;
      e_dout = 8'((m_wdata >> (8 * j)) & 32'hFF);
      mram[e_a[15:0]] = e_dout;
    end else begin
      e_wr = 1'b0;
    end
  endtask

  task automatic start_txn();
    longint      v;
    logic [31:0] a;
    m_phase = 1;
    m_j = 0;
    drive_offset(0);
    if (m_kind != 2) begin
      v = 0;
      for (int i = 0; i < m_n; i++) begin
        a = m_addr + 32'(i);
        v = v + (longint'(mram[a[15:0]]) << (8 * i));
      end
      if (m_kind == 1 && !m_uns) begin
        if (m_n == 1 && v >= 128) v = v - 256;
        if (m_n == 2 && v >= 32768) v = v - 65536;
      end
      m_result = v[31:0];
    end
  endtask

  task automatic model_step();
    logic stall;
    if (rst_in) begin
      m_phase = 0; e_a = 0; e_wr = 0; e_dout = 0;
      e_fd = 0; e_fl = 0; e_fs = 0; e_fdata = 0; e_ldata = 0;
    end else if (rdy_in) begin
      e_fd = 0; e_fl = 0; e_fs = 0;
      case (m_phase)
        0: begin
          e_a = 0; e_wr = 0;
          if (roll_back) begin e_fdata = 0; e_ldata = 0; end
`ifdef IO_STALL_EN
          stall = lsb_store && io_buffer_full && (store_address[17:16] == 2'b11);
`else
          stall = 1'b0;
`endif
          if (lsb_store) begin
            if (!stall) begin
              m_kind = 2; m_addr = store_address; m_n = n_of(store_size);
              m_wdata = data_store; start_txn();
            end
          end else if (!roll_back && lsb_load) begin
            m_kind = 1; m_addr = load_address; m_n = n_of(load_size);
            m_uns = load_unsigned; start_txn();
          end else if (!roll_back && fetch_req) begin
            m_kind = 0; m_addr = fetch_addr; m_n = 4; m_uns = 0; start_txn();
          end
        end
        1: begin
          if (m_kind != 2 && roll_back) begin
            m_phase = 0; e_a = 0; e_fdata = 0; e_ldata = 0;
          end else begin
            m_j++;
            if (m_j < m_n) begin
              drive_offset(m_j);
            end else begin
              e_a = 0; e_wr = 0; m_phase = 2;
              if (m_kind == 2) e_fs = 1;
              else if (m_kind == 1) begin e_fl = 1; e_ldata = m_result; end
              else begin e_fd = 1; e_fdata = m_result; end
            end
          end
        end
        default: begin
          m_phase = 0;
          if (roll_back) begin e_fdata = 0; e_ldata = 0; end
        end
      endcase
    end
  endtask

  task automatic compare();
    chk("mem_a", mem_a, e_a);
    chk("mem_wr", 32'(mem_wr), 32'(e_wr));
    if (e_wr) chk("mem_dout", 32'(mem_dout), 32'(e_dout));
    chk("fetch_done", 32'(fetch_done), 32'(e_fd));
    chk("finish_load", 32'(finish_load), 32'(e_fl));
    chk("finish_store", 32'(finish_store), 32'(e_fs));
    if (e_fd) chk("fetch_data", fetch_data, e_fdata);
    if (e_fl) chk("data_load", data_load, e_ldata);
  endtask

  // One clock: RAM write from the pre-edge bus, model update, output compare.
  task automatic tick();
    logic        pre_wr;
    logic [31:0] pre_a;
    logic [7:0]  pre_d;
    pre_wr = mem_wr; pre_a = mem_a; pre_d = mem_dout;
    @(posedge clk_in);
    model_step();
    #1;
    if (pre_wr === 1'b1) ram[pre_a[15:0]] = pre_d;
    compare();
  endtask

  function automatic logic pulse(input int which);
    return (which == 0) ? fetch_done : (which == 1) ? finish_load : finish_store;
  endfunction

  task automatic run_until(input int which, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (pulse(which) !== 1'b1 && cycles < budget);
    if (pulse(which) !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout waiting for done pulse %0d after %0d cycles", which, cycles);
    end
  endtask

  task automatic set_ram(input logic [31:0] a, input logic [7:0] d);
    ram[a[15:0]] = d;
    mram[a[15:0]] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, cnt, ts, tl, tf, t;
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = 8'(i) ^ 8'(i >> 8);
      mram[i] = 8'(i) ^ 8'(i >> 8);
    end
    rst_in = 1; rdy_in = 1; roll_back = 0; io_buffer_full = 0;
    fetch_req = 0; fetch_addr = 0; lsb_load = 0; load_address = 0; load_size = 0;
    load_unsigned = 0; lsb_store = 0; store_address = 0; store_size = 0; data_store = 0;
    tick(); tick();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_data_load", data_load, 32'h0);
    chk("rst_fetch_data", fetch_data, 32'h0);
    rst_in = 0;
    tick();

    // Word load
    set_ram(32'h100, 8'h11); set_ram(32'h101, 8'h22);
    set_ram(32'h102, 8'h33); set_ram(32'h103, 8'h44);
    lsb_load = 1; load_address = 32'h100; load_size = 2'b10; load_unsigned = 0;
    run_until(1, 20, c);
    lsb_load = 0;
    chk("word_load_latency", c, 5);
    chk("word_load_data", data_load, 32'h44332211);
    tick(); tick();

    // Byte loads, signed and unsigned, and a signed half load
    set_ram(32'h8, 8'h80);
    lsb_load = 1; load_address = 32'h8; load_size = 2'b00; load_unsigned = 0;
    run_until(1, 20, c);
    lsb_load = 0;
    chk("byte_load_latency", c, 2);
    chk("byte_load_signed", data_load, 32'hFFFFFF80);
    tick();
    lsb_load = 1; load_unsigned = 1;
    run_until(1, 20, c);
    lsb_load = 0;
    chk("byte_load_unsigned", data_load, 32'h00000080);
    tick();
    set_ram(32'h20, 8'h34); set_ram(32'h21, 8'h82);
    lsb_load = 1; load_address = 32'h20; load_size = 2'b01; load_unsigned = 0;
    run_until(1, 20, c);
    lsb_load = 0;
    chk("half_load_signed", data_load, 32'hFFFF8234);
    tick(); tick();

    // Half store
    lsb_store = 1; store_address = 32'h200; store_size = 2'b01; data_store = 32'h1234ABCD;
    run_until(2, 20, c);
    lsb_store = 0;
    chk("half_store_latency", c, 3);
    tick();
    chk("half_store_wr_after", 32'(mem_wr), 32'h0);
    chk("half_store_bytes", {16'h0, ram[16'h201], ram[16'h200]}, 32'h0000ABCD);
    tick();

    // All three requesters at once
    lsb_store = 1; store_address = 32'h300; store_size = 2'b10; data_store = 32'hDEADBEEF;
    lsb_load = 1; load_address = 32'h300; load_size = 2'b10; load_unsigned = 0;
    fetch_req = 1; fetch_addr = 32'h100;
    ts = -1; tl = -1; tf = -1; t = 0;
    for (int i = 0; i < 60 && (fetch_req || lsb_load || lsb_store); i++) begin
      tick();
      t++;
      if (finish_store === 1'b1) begin ts = t; lsb_store = 0; end
      if (finish_load === 1'b1) begin
        tl = t; lsb_load = 0;
        chk("prio_load_data", data_load, 32'hDEADBEEF);
      end
      if (fetch_done === 1'b1) begin
        tf = t; fetch_req = 0;
        chk("prio_fetch_data", fetch_data, 32'h44332211);
      end
    end
    chk("prio_store_done", ts, 5);
    chk("prio_load_gap", tl - ts, 6);
    chk("prio_fetch_gap", tf - tl, 6);
    tick(); tick();

    // roll_back in IDLE: load ignored, store still accepted
    roll_back = 1; lsb_load = 1; load_address = 32'h100; load_size = 2'b10;
    tick(); tick(); tick();
    chk("rb_idle_no_load", mem_a, 32'h0);
    lsb_load = 0;
    lsb_store = 1; store_address = 32'h500; store_size = 2'b00; data_store = 32'h77;
    run_until(2, 10, c);
    lsb_store = 0;
    chk("rb_idle_store_latency", c, 2);
    roll_back = 0;
    tick(); tick();

    // roll_back one cycle into a word load
    lsb_load = 1; load_address = 32'h100; load_size = 2'b10;
    tick();
    roll_back = 1; lsb_load = 0;
    tick();
    chk("rb_read_mem_a", mem_a, 32'h0);
    roll_back = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (finish_load === 1'b1) cnt++;
    end
    chk("rb_read_no_done", cnt, 0);

    // roll_back during a word store
    lsb_store = 1; store_address = 32'h400; store_size = 2'b10; data_store = 32'h01020304;
    tick();
    roll_back = 1;
    run_until(2, 10, c);
    lsb_store = 0;
    chk("rb_store_latency", c, 4);
    tick();
    roll_back = 0;
    tick();
    chk("rb_store_bytes", {ram[16'h403], ram[16'h402], ram[16'h401], ram[16'h400]},
        32'h01020304);

    // rdy_in low mid-read
    lsb_load = 1; load_address = 32'h100; load_size = 2'b10;
    tick(); tick();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_freeze_mem_a", mem_a, 32'h101);
    end
    rdy_in = 1;
    run_until(1, 10, c);
    lsb_load = 0;
    chk("rdy_resume_latency", c, 3);
    chk("rdy_resume_data", data_load, 32'h44332211);
    tick(); tick();

    // IO store with the UART buffer full
    io_buffer_full = 1;
    lsb_store = 1; store_address = 32'h30000; store_size = 2'b00; data_store = 32'h5A;
`ifdef IO_STALL_EN
    lsb_load = 1; load_address = 32'h100; load_size = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("io_stall_wr", 32'(mem_wr), 32'h0);
    end
    io_buffer_full = 0;
    run_until(2, 10, c);
    lsb_store = 0;
    chk("io_release_latency", c, 2);
    run_until(1, 20, c);
    lsb_load = 0;
    chk("io_then_load_latency", c, 6);
    chk("io_then_load_data", data_load, 32'h44332211);
`else
    run_until(2, 10, c);
    lsb_store = 0;
    io_buffer_full = 0;
    chk("io_ignored_latency", c, 2);
`endif
    tick();
    chk("io_store_byte", 32'(ram[16'h0000]), 32'h5A);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial controller that shares the single 8-bit RAM port between instruction fetch and the load/store buffer. It accepts one word/half/byte request at a time and sequences the byte accesses. It sign- or zero-extends load data and returns a one-cycle completion pulse to the winning requester. Committed stores survive rollback; speculative loads and fetches are aborted by it.

## Interface
- No parameters.
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global ready; low freezes all state and outputs
- roll_back  input  1  mispredict flush
- io_buffer_full  input  1  UART write buffer full
- mem_din  input  8  RAM read data; valid the cycle after its address
- mem_dout  output  8  RAM write data
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write, 0 = read
- fetch_req  input  1  fetch request (level, held until done)
- fetch_addr  input  32  word-aligned fetch address
- fetch_done  output  1  one-cycle completion pulse
- fetch_data  output  32  fetched word, little-endian
- lsb_load  input  1  load request (level)
- load_address  input  32  load byte address
- load_size  input  2  00 byte, 01 half, 10 word
- load_unsigned  input  1  zero-extend when 1
- finish_load  output  1  one-cycle completion pulse
- data_load  output  32  extended load result
- lsb_store  input  1  store request (level)
- store_address  input  32  store byte address
- store_size  input  2  00 byte, 01 half, 10 word
- data_store  input  32  store data; low bytes used
- finish_store  output  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE samples requests with priority store > load > fetch.
  - Latches the address, byte count N (1/2/4), the source and the store data.
  - Enters WRITE for a store, READ otherwise.
- READ:
  - Acceptance edge drives mem_a=addr, mem_wr=0, and sets byte counter k=0.
  - Each following edge captures mem_din into byte k of the buffer, increments k, and drives mem_a=addr+k while k<N.
  - The edge capturing byte N-1 drives mem_a=0, raises the source's done pulse with the assembled data, and enters DONE.
- WRITE:
  - Acceptance edge drives mem_a=addr, mem_dout=data[7:0], mem_wr=1.
  - Subsequent edges drive bytes 1..N-1 at addr+1..addr+N-1.
  - Edge N drives mem_wr=0, mem_a=0, pulses finish_store, and enters DONE.
- DONE: one idle cycle, no request sampled, then IDLE. This lets requesters drop their level request after seeing done.
- Extension:
  - Byte loads extend from bit 7; half loads from bit 15.
  - When load_unsigned=1, extension is zero; otherwise it is sign extension.
  - Word loads are not extended.
- Address arithmetic is 32-bit wrap; no alignment check is performed.
- Only one done pulse is ever high in a cycle.

## Timing
- Reset values (and roll_back values, except during WRITE): state IDLE, mem_a=0, mem_dout=0, mem_wr=0, all done pulses 0, fetch_data=0, data_load=0.
- Latency: done pulse is high in the cycle after edge N, where edge 0 is the acceptance edge.
  - Word read or word write: 4 cycles.
  - Byte: 1 cycle.
- Back-to-back: the earliest next acceptance is edge N+2.
- roll_back high at an edge:
  - In READ: abort, mem_a=0, no done pulse, go to IDLE.
  - In WRITE: ignored; the committed store completes normally.
  - In IDLE: the load and fetch requests are ignored that edge; a store may still be accepted.
- roll_back during DONE: go to IDLE; the pending done pulse is cleared.
- rdy_in low: every register holds, including mem_wr and the counter; resumes exactly where it stopped.
- rst_in has precedence over rdy_in and roll_back.

## Configuration
- IO_STALL_EN defined:
  - A store with store_address[17:16]==2'b11 is not accepted in IDLE while io_buffer_full=1.
  - Lower-priority requests are not accepted that cycle either, so memory order is preserved.
- IO_STALL_EN undefined: io_buffer_full is ignored.

## Test plan
- Word load, addr 0x100, RAM bytes 0x11,0x22,0x33,0x44 → mem_a 0x100..0x103 on consecutive cycles; finish_load with data_load=0x44332211 four cycles after acceptance.
- Byte load, addr 0x8, byte 0x80 → data_load=0xFFFFFF80 when signed; with load_unsigned=1 → 0x00000080. Half load, bytes 0x34,0x82 → data_load=0xFFFF8234 signed.
- Half store 0xABCD at 0x200 → mem_wr=1 with (0x200,0xCD) then (0x201,0xAB); finish_store next cycle; mem_wr=0 afterwards.
- lsb_store, lsb_load and fetch_req all asserted → store served first, then load, then fetch; each accepted two cycles after the previous done pulse.
- roll_back one cycle into a word load → no finish_load, mem_a=0, IDLE. roll_back during a word store → all four bytes written, finish_store pulses.
- IO_STALL_EN defined: store to 0x30000 with io_buffer_full=1 for 5 cycles → mem_wr stays 0. When the flag drops, a 1-byte write is issued and finish_store follows. rdy_in low mid-read → mem_a frozen; read completes with correct data after release.
